// File: rtl/ram_block_copy_master.sv
// ram_block_copy_master: word-at-a-time block copy engine for the 16-bit x 4K
// single-port RAM interface. Reads one source word, writes it to the
// destination, and repeats until LENGTH words are copied or abort is seen.
// READ_LATENCY selects a combinatorial (0) or one-cycle registered (1) RAM.
// Optional feature macro: RAM_BLOCK_COPY_CHECKSUM_EN (running sum of words written).
module ram_block_copy_master #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] src_addr,
  input  logic [11:0] dst_addr,
  input  logic [12:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [12:0] words_done,
  output logic [11:0] address,
  output logic        read,
  output logic        write,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  output logic [15:0] checksum
);

  if (READ_LATENCY > 1) begin : g_bad_latency
    $fatal(1, "ram_block_copy_master: READ_LATENCY must be 0 or 1");
  end

  typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StFin} state_e;

  state_e      state_q, state_d;
  logic [11:0] src_q, src_d;
  logic [11:0] dst_q, dst_d;
  logic [12:0] len_q, len_d;
  logic [15:0] buf_q, buf_d;
  logic [12:0] words_q, words_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      words_q <= words_d;
    end
  end

  // Next-state and RAM-side outputs; outputs are decoded from state so an
  // asynchronous reset drops them without waiting for a clock edge.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    words_d   = words_q;
    busy      = 1'b0;
    done      = 1'b0;
    address   = 12'h000;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 16'h0000;

    case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          words_d = '0;
          state_d = (length == 13'd0) ? StFin : StRd;
        end
      end
      StRd: begin
        busy    = 1'b1;
        address = src_q;
        read    = 1'b1;
        if (abort) begin
          state_d = StFin;
        end else if (READ_LATENCY == 0) begin
          buf_d   = readdata;
          state_d = StWr;
        end else begin
          state_d = StRwait;
        end
      end
      StRwait: begin
        busy    = 1'b1;
        address = src_q;
        read    = 1'b1;
        if (abort) begin
          state_d = StFin;
        end else begin
          buf_d   = readdata;
          state_d = StWr;
        end
      end
      StWr: begin
        busy = 1'b1;
        if (abort) begin
          // Write is suppressed; the word is not counted.
          state_d = StFin;
        end else begin
          address   = dst_q;
          write     = 1'b1;
          writedata = buf_q;
          src_d     = src_q + 12'd1;
          dst_d     = dst_q + 12'd1;
          words_d   = words_q + 13'd1;
          state_d   = (words_q + 13'd1 == len_q) ? StFin : StRd;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign words_done = words_q;

`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
  logic [15:0] csum_q;

  // Wrapping sum of every word actually written; cleared on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 16'h0000;
    end else if (state_q == StIdle && start) begin
      csum_q <= 16'h0000;
    end else if (write) begin
      csum_q <= csum_q + writedata;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_block_copy_master.sv
// Directed bench for ram_block_copy_master: one instance per READ_LATENCY,
// each with its own 4K x 16 RAM model. Cycle numbers count the start cycle as 1.
module tb_ram_block_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [11:0] src_addr, dst_addr;
  logic [12:0] length;
  logic        abort;

  logic        busy0, done0, read0, write0;
  logic [12:0] words_done0;
  logic [11:0] address0;
  logic [15:0] writedata0, readdata0, checksum0;

  logic        busy1, done1, read1, write1;
  logic [12:0] words_done1;
  logic [11:0] address1;
  logic [15:0] writedata1, readdata1, checksum1, rdq1;

  logic        poke_en, poke_sel;
  logic [11:0] poke_addr;
  logic [15:0] poke_data;

  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];

  int n_checks = 0;
  int n_fail   = 0;

  int mon_reads, mon_writes, mon_both, mon_runbad, done_cyc;
  logic done_busy;

  always #5 clk = ~clk;

  ram_block_copy_master #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .abort(abort), .busy(busy0), .done(done0), .words_done(words_done0),
    .address(address0), .read(read0), .write(write0), .writedata(writedata0),
    .readdata(readdata0), .checksum(checksum0)
  );

  ram_block_copy_master #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .abort(abort), .busy(busy1), .done(done1), .words_done(words_done1),
    .address(address1), .read(read1), .write(write1), .writedata(writedata1),
    .readdata(readdata1), .checksum(checksum1)
  );

  // RAM models: mem0 is combinatorial read, mem1 has one cycle of read latency.
  always @(posedge clk) begin
    if (poke_en && !poke_sel) mem0[poke_addr] <= poke_data;
    else if (write0)          mem0[address0] <= writedata0;
    if (poke_en && poke_sel)  mem1[poke_addr] <= poke_data;
    else if (write1)          mem1[address1] <= writedata1;
    rdq1 <= mem1[address1];
  end
  assign readdata0 = mem0[address0];
  assign readdata1 = rdq1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic sel, input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic check_mem(input logic sel, input string tag, input logic [11:0] a,
                           input logic [15:0] exp);
    check_eq(tag, sel ? mem1[a] : mem0[a], exp);
  endtask

  task automatic sample(input int sel, output logic rd, output logic wr, output logic dn,
                        output logic bs);
    rd = sel ? read1 : read0;
    wr = sel ? write1 : write0;
    dn = sel ? done1 : done0;
    bs = sel ? busy1 : busy0;
  endtask

  // Issue one copy and monitor it until done (bounded). abort_wr>0 aborts during
  // that WR cycle; restart_cyc>0 pulses a second start with other operands.
  task automatic run_copy(input int sel, input logic [11:0] s, input logic [11:0] d,
                          input logic [12:0] n, input int abort_wr, input int restart_cyc);
    int run, wr_seen;
    logic rd, wr, dn, bs;
    mon_reads = 0; mon_writes = 0; mon_both = 0; mon_runbad = 0; done_cyc = 0;
    done_busy = 1'b1; run = 0; wr_seen = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int cyc = 2; cyc < 200; cyc++) begin
      sample(sel, rd, wr, dn, bs);
      if (restart_cyc == cyc) begin
        src_addr = 12'h020; dst_addr = 12'h400; length = 13'd2;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (wr && abort_wr == wr_seen + 1) begin
        abort = 1'b1;
        #1;
        sample(sel, rd, wr, dn, bs);
        check_eq("abort_write_low", {31'd0, wr}, 32'd0);
      end
      if (rd && wr) mon_both++;
      if (rd) begin
        mon_reads++;
        run++;
      end else begin
        if (run != 0 && run != 1 + sel) mon_runbad++;
        run = 0;
      end
      if (wr) begin
        mon_writes++;
        wr_seen++;
      end
      if (dn) begin
        done_cyc  = cyc;
        done_busy = bs;
        break;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    end
    start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    poke_en = 1'b0; poke_sel = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (2) @(negedge clk);
    // Reset state
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_rw", {30'd0, read0, write0}, 32'd0);
    check_eq("rst_addr", {20'd0, address0}, 32'd0);
    check_eq("rst_wdata", {16'd0, writedata0}, 32'd0);
    check_eq("rst_words", {19'd0, words_done0}, 32'd0);
    check_eq("rst_csum", {16'd0, checksum0}, 32'd0);
    reset = 1'b0;

    // Latency 0 basic copy
    poke(0, 12'h010, 16'h1111); poke(0, 12'h011, 16'h2222);
    poke(0, 12'h012, 16'h3333); poke(0, 12'h013, 16'h4444);
    poke(0, 12'h104, 16'hBEEF);
    run_copy(0, 12'h010, 12'h100, 13'd4, 0, 0);
    check_eq("l0_done_cyc", done_cyc, 32'd10);
    check_eq("l0_busy_at_done", {31'd0, done_busy}, 32'd0);
    check_eq("l0_words", {19'd0, words_done0}, 32'd4);
    check_eq("l0_reads", mon_reads, 32'd4);
    check_eq("l0_writes", mon_writes, 32'd4);
    check_eq("l0_rw_overlap", mon_both, 32'd0);
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    check_eq("l0_csum", {16'd0, checksum0}, 32'h0000AAAA);
`else
    check_eq("l0_csum", {16'd0, checksum0}, 32'd0);
`endif
    @(negedge clk);
    check_eq("l0_words_hold", {19'd0, words_done0}, 32'd4);
    check_mem(0, "l0_m100", 12'h100, 16'h1111);
    check_mem(0, "l0_m101", 12'h101, 16'h2222);
    check_mem(0, "l0_m102", 12'h102, 16'h3333);
    check_mem(0, "l0_m103", 12'h103, 16'h4444);
    check_mem(0, "l0_m104", 12'h104, 16'hBEEF);

    // Latency 1 copy
    poke(1, 12'h010, 16'h1111); poke(1, 12'h011, 16'h2222);
    poke(1, 12'h012, 16'h3333); poke(1, 12'h013, 16'h4444);
    run_copy(1, 12'h010, 12'h100, 13'd4, 0, 0);
    check_eq("l1_done_cyc", done_cyc, 32'd14);
    check_eq("l1_reads", mon_reads, 32'd8);
    check_eq("l1_read_runs", mon_runbad, 32'd0);
    check_eq("l1_rw_overlap", mon_both, 32'd0);
    check_eq("l1_words", {19'd0, words_done1}, 32'd4);
    @(negedge clk);
    check_mem(1, "l1_m100", 12'h100, 16'h1111);
    check_mem(1, "l1_m101", 12'h101, 16'h2222);
    check_mem(1, "l1_m102", 12'h102, 16'h3333);
    check_mem(1, "l1_m103", 12'h103, 16'h4444);

    // Zero length
    run_copy(0, 12'h050, 12'h060, 13'd0, 0, 0);
    check_eq("z_done_cyc", done_cyc, 32'd2);
    check_eq("z_reads", mon_reads, 32'd0);
    check_eq("z_writes", mon_writes, 32'd0);
    check_eq("z_words", {19'd0, words_done0}, 32'd0);

    // Start while busy is ignored
    poke(0, 12'h400, 16'hDEAD);
    run_copy(0, 12'h010, 12'h300, 13'd4, 0, 4);
    check_eq("rs_done_cyc", done_cyc, 32'd10);
    check_eq("rs_words", {19'd0, words_done0}, 32'd4);
    @(negedge clk);
    check_mem(0, "rs_m300", 12'h300, 16'h1111);
    check_mem(0, "rs_m303", 12'h303, 16'h4444);
    check_mem(0, "rs_m400", 12'h400, 16'hDEAD);

    // Abort during the third WR cycle
    poke(0, 12'h020, 16'h0005); poke(0, 12'h021, 16'h0006); poke(0, 12'h022, 16'h0007);
    poke(0, 12'h502, 16'h7777);
    run_copy(0, 12'h020, 12'h500, 13'd8, 3, 0);
    check_eq("ab_done_cyc", done_cyc, 32'd8);
    check_eq("ab_writes", mon_writes, 32'd2);
    check_eq("ab_words", {19'd0, words_done0}, 32'd2);
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    check_eq("ab_csum", {16'd0, checksum0}, 32'h0000000B);
`else
    check_eq("ab_csum", {16'd0, checksum0}, 32'd0);
`endif
    @(negedge clk);
    check_mem(0, "ab_m500", 12'h500, 16'h0005);
    check_mem(0, "ab_m501", 12'h501, 16'h0006);
    check_mem(0, "ab_m502", 12'h502, 16'h7777);

    // Overlapping regions: ascending copy propagates the first word
    poke(0, 12'h200, 16'h00A1); poke(0, 12'h201, 16'h00A2);
    poke(0, 12'h202, 16'h00A3); poke(0, 12'h203, 16'h00A4);
    run_copy(0, 12'h200, 12'h201, 13'd3, 0, 0);
    @(negedge clk);
    check_mem(0, "ov_m201", 12'h201, 16'h00A1);
    check_mem(0, "ov_m202", 12'h202, 16'h00A1);
    check_mem(0, "ov_m203", 12'h203, 16'h00A1);

    // Asynchronous reset while in RD
    poke(0, 12'h600, 16'h5A5A);
    @(negedge clk);
    src_addr = 12'h010; dst_addr = 12'h600; length = 13'd4; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check_eq("ar_read_before", {31'd0, read0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_busy", {31'd0, busy0}, 32'd0);
    check_eq("ar_rw", {30'd0, read0, write0}, 32'd0);
    check_eq("ar_addr", {20'd0, address0}, 32'd0);
    check_eq("ar_words", {19'd0, words_done0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_mem(0, "ar_m600", 12'h600, 16'h5A5A);

    // Wrap-around after reset
    poke(0, 12'hFFE, 16'h000A); poke(0, 12'hFFF, 16'h000B); poke(0, 12'h000, 16'h000C);
    run_copy(0, 12'hFFE, 12'h7FF, 13'd3, 0, 0);
    check_eq("wr_done_cyc", done_cyc, 32'd8);
    check_eq("wr_words", {19'd0, words_done0}, 32'd3);
    @(negedge clk);
    check_mem(0, "wr_m7ff", 12'h7FF, 16'h000A);
    check_mem(0, "wr_m800", 12'h800, 16'h000B);
    check_mem(0, "wr_m801", 12'h801, 16'h000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_block_copy_master.md
Name: ram_block_copy_master

Overview:
- Initiator-side engine for the 16-bit x 4K single-port RAM interface (address/read/write/writedata/readdata).
- Copies a block of LENGTH words from a source region to a destination region in the same RAM, one word at a time.
- Sits beside the MU0 CPU as a simple DMA helper, sharing the RAM port through an external mux.
- Supports zero-delay RAMs (combinatorial readdata) and one-cycle-delay RAMs, selected by parameter.

Parameters:
- READ_LATENCY, 0, cycles from read/address asserted to readdata valid. Legal values are 0 and 1; any other value is a $fatal at elaboration.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- src_addr  input  12  first source word address, latched on start.
- dst_addr  input  12  first destination word address, latched on start.
- length  input  13  number of words to copy (0..4096), latched on start.
- abort  input  1  terminate the transfer early.
- busy  output  1  high from the cycle after start until the cycle done pulses.
- done  output  1  one-cycle pulse at transfer completion or abort.
- words_done  output  13  count of words written; holds its value after done until the next start.
- address  output  12  RAM address.
- read  output  1  RAM read enable.
- write  output  1  RAM write enable.
- writedata  output  16  RAM write data.
- readdata  input  16  RAM read data.
- checksum  output  16  see Optional Feature.

Behaviour:
- Reset (asynchronous): state=IDLE. address, read, write, writedata, busy, done, words_done and checksum are all 0.
- States: IDLE, RD, RWAIT (present only when READ_LATENCY=1), WR, FIN.
- IDLE:
  - read=0, write=0.
  - start=1 latches src/dst/length, clears words_done and moves to RD.
  - If the latched length=0, move to FIN instead.
- RD: address=src_ptr, read=1, write=0.
  - READ_LATENCY=0: capture readdata into the data buffer at this clock edge, then go to WR.
  - READ_LATENCY=1: go to RWAIT.
- RWAIT: address and read held as in RD. Capture readdata at this edge, then go to WR.
- WR: address=dst_ptr, write=1, read=0, writedata=buffer.
  - At the clock edge: src_ptr+1, dst_ptr+1, words_done+1.
  - Next state is FIN if words_done+1==length, else RD.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Throughput: 2 cycles/word at READ_LATENCY=0, 3 cycles/word at READ_LATENCY=1.
- Transfer latency from start to the done pulse: 1 + length*(2+READ_LATENCY) + 1 cycles. Length 0 gives done 2 cycles after start.
- Pointers are 12 bits and wrap modulo 4096. 0xFFF+1 becomes 0x000, with no error.
- read and write are never high in the same cycle.
- address is don't-care when both read and write are 0; drive 0.
- start while busy is ignored; latched values do not change.
- abort=1 in RD, RWAIT or WR:
  - A write in progress that cycle is suppressed (write forced to 0).
  - Next state is FIN; words_done is unchanged.
- abort in IDLE or FIN: no effect.
- abort and start high in the same IDLE cycle: start wins and abort is ignored.
- Overlapping regions: the copy is strictly ascending. With dst in (src, src+length), the source is overwritten before it is read, and this is the defined behaviour; the bench models it.
- Asynchronous reset mid-transfer: immediately IDLE with all outputs 0. The RAM contents are whatever was already written.

Optional Feature:
- Macro: RAM_BLOCK_COPY_CHECKSUM_EN.
- Defined:
  - checksum is a 16-bit wrapping sum of every word written, updated at each WR edge.
  - It is cleared on an accepted start and holds after done.
  - Suppressed (aborted) writes are not summed.
- Undefined: checksum is tied to 16'h0000 and no adder is present.

Test Plan:
- Latency 0 basic copy:
  - Stimulus: READ_LATENCY=0, RAM[0x010..0x013]={0x1111,0x2222,0x3333,0x4444}; start with src=0x010, dst=0x100, length=4.
  - Required: RAM[0x100..0x103] holds the same values; done at cycle 10 after start; words_done=4; checksum=0xAAAA when the macro is defined.
- Latency 1 copy:
  - Stimulus: READ_LATENCY=1, same data as above.
  - Required: identical RAM result; done at cycle 14; read held high for 2 consecutive cycles per word.
- Wrap-around:
  - Stimulus: src=0xFFE, dst=0x7FF, length=3, with RAM[0xFFE]=0xA, RAM[0xFFF]=0xB, RAM[0x000]=0xC.
  - Required: RAM[0x7FF..0x801]={0xA,0xB,0xC}.
- Zero length, and start while busy:
  - Stimulus: length=0.
  - Required: done 2 cycles after start, no read or write asserted.
  - Stimulus: a second start issued mid-transfer.
  - Required: the second start is ignored; the original copy completes unchanged.
- Abort:
  - Stimulus: length=8, abort asserted during the 3rd WR cycle.
  - Required: only 2 words written, no write in the abort cycle, done next cycle, words_done=2.
- Reset mid-transfer:
  - Stimulus: reset asserted between clock edges during RD.
  - Required: busy, read and write go to 0 before the next edge; the next start works normally.
